// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF/D requester handshakes and the single-port memory bus
// seen by mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [DW-1:0] if_rdata_o;

  logic          d_req_i;
  logic          d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic          d_gnt_o;
  logic          d_rvalid_o;
  logic [DW-1:0] d_rdata_o;

  logic          mem_en_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the data port;
// D has priority, a starvation counter forces an IF win after STARVE_MAX losses.
module mem_port_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 3
) (
  input logic              clk_i,
  input logic              rst_i,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, RD_IF, RD_D} state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          if_gnt;
  logic          d_gnt;
  logic          d_rd;
  logic          if_rvalid;
  logic          d_rvalid;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;

  // Grants are gated by reset so the memory strobe drops asynchronously too.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst_i) begin
      if (bus.d_req_i && !(bus.if_req_i && starve_cnt == STARVE_LIM))
        d_gnt = 1'b1;
      else if (bus.if_req_i)
        if_gnt = 1'b1;
    end
  end

  assign d_rd = d_gnt & ~bus.d_we_i;

  always_comb begin
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (d_gnt) begin
      bus.mem_addr_o = bus.d_addr_i;
      if (bus.d_we_i)
        bus.mem_wdata_o = bus.d_wdata_i;
    end else if (if_gnt) begin
      bus.mem_addr_o = bus.if_addr_i;
    end
  end

  assign bus.if_gnt_o    = if_gnt;
  assign bus.d_gnt_o     = d_gnt;
  assign bus.mem_en_o    = if_gnt | d_gnt;
  assign bus.mem_we_o    = d_gnt & bus.d_we_i;
  assign bus.if_rvalid_o = if_rvalid;
  assign bus.d_rvalid_o  = d_rvalid;

  // Memory data arrives in the response cycle itself, so it is passed straight
  // through then and captured for the hold value afterwards.
  assign bus.if_rdata_o = (state == RD_IF) ? bus.mem_rdata_i : if_rdata_q;
  assign bus.d_rdata_o  = (state == RD_D)  ? bus.mem_rdata_i : d_rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      starve_cnt <= '0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        RD_IF:   if_rdata_q <= bus.mem_rdata_i;
        RD_D:    d_rdata_q  <= bus.mem_rdata_i;
        default: ;
      endcase

      if (if_gnt)
        state <= RD_IF;
      else if (d_rd)
        state <= RD_D;
      else
        state <= IDLE;

      if_rvalid <= if_gnt;
      d_rvalid  <= d_rd;

      if (bus.if_req_i && !if_gnt) begin
        if (starve_cnt != STARVE_LIM)
          starve_cnt <= starve_cnt + CW'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven grant vectors, hand
// sequences for the multi-cycle corners, and a read-data scoreboard.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DW(32), .AW(5)) bus ();

  mem_port_arbiter #(.DW(32), .AW(5), .STARVE_MAX(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Memory component driven by the DUT's port.
  logic [31:0] ram [32];
  logic [31:0] ram_q = '0;
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) ram[bus.mem_addr_o] <= bus.mem_wdata_o;
      else              ram_q <= ram[bus.mem_addr_o];
    end
  end
  assign bus.mem_rdata_i = ram_q;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // Reference model and scoreboard
  logic [31:0] ref_mem [32];
  logic [31:0] q_if [$];
  logic [31:0] q_d  [$];
  int          m_cnt = 0;
  logic        m_if_pend = 1'b0;
  logic        m_d_pend  = 1'b0;
  logic [31:0] m_if_hold = '0;
  logic [31:0] m_d_hold  = '0;

  always @(negedge clk) begin
    logic e_if, e_d;
    logic [31:0] exp_w;
    if (rst) begin
      chk1("rst_if_gnt", bus.if_gnt_o, 1'b0);
      chk1("rst_d_gnt", bus.d_gnt_o, 1'b0);
      chk1("rst_if_rvalid", bus.if_rvalid_o, 1'b0);
      chk1("rst_d_rvalid", bus.d_rvalid_o, 1'b0);
      chk1("rst_mem_en", bus.mem_en_o, 1'b0);
      chk("rst_if_rdata", bus.if_rdata_o, 32'h0);
      chk("rst_d_rdata", bus.d_rdata_o, 32'h0);
      m_cnt = 0; m_if_pend = 1'b0; m_d_pend = 1'b0;
      m_if_hold = '0; m_d_hold = '0;
      q_if.delete(); q_d.delete();
    end else begin
      e_if = bus.if_req_i && (!bus.d_req_i || m_cnt == 3);
      e_d  = bus.d_req_i && !e_if;
      chk1("if_gnt", bus.if_gnt_o, e_if);
      chk1("d_gnt", bus.d_gnt_o, e_d);
      chk1("mem_en", bus.mem_en_o, e_if | e_d);
      chk1("mem_we", bus.mem_we_o, e_d & bus.d_we_i);
      chk("mem_addr", 32'(bus.mem_addr_o),
          e_d ? 32'(bus.d_addr_i) : (e_if ? 32'(bus.if_addr_i) : 32'h0));
      if (e_d && bus.d_we_i) chk("mem_wdata", bus.mem_wdata_o, bus.d_wdata_i);
      else if (!e_d && !e_if) chk("mem_wdata_idle", bus.mem_wdata_o, 32'h0);

      chk1("if_rvalid", bus.if_rvalid_o, m_if_pend);
      if (m_if_pend && q_if.size() > 0) m_if_hold = q_if.pop_front();
      chk("if_rdata", bus.if_rdata_o, m_if_hold);
      chk1("d_rvalid", bus.d_rvalid_o, m_d_pend);
      if (m_d_pend && q_d.size() > 0) m_d_hold = q_d.pop_front();
      chk("d_rdata", bus.d_rdata_o, m_d_hold);

      m_if_pend = e_if;
      m_d_pend  = e_d && !bus.d_we_i;
      if (e_if) q_if.push_back(ref_mem[bus.if_addr_i]);
      if (e_d && !bus.d_we_i) q_d.push_back(ref_mem[bus.d_addr_i]);
      if (e_d && bus.d_we_i) begin
        exp_w = bus.d_wdata_i;
        ref_mem[bus.d_addr_i] = exp_w;
      end
      if (bus.if_req_i && !e_if) m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
      else                       m_cnt = 0;
    end
  end

  typedef struct {
    logic        if_req;
    logic [4:0]  if_addr;
    logic        d_req;
    logic        d_we;
    logic [4:0]  d_addr;
    logic [31:0] d_wdata;
    logic        exp_if_gnt;
    logic        exp_d_gnt;
    int          exp_cnt;   // -1: not checked
  } vec_t;

  vec_t tbl [$];

  function automatic void add(input logic ir, input int ia, input logic dr, input logic dw,
                              input int da, input logic [31:0] wd,
                              input logic ei, input logic ed, input int ec);
    vec_t v;
    v.if_req = ir; v.if_addr = 5'(ia); v.d_req = dr; v.d_we = dw;
    v.d_addr = 5'(da); v.d_wdata = wd; v.exp_if_gnt = ei; v.exp_d_gnt = ed; v.exp_cnt = ec;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic ir, input int ia, input logic dr, input logic dw,
                       input int da, input logic [31:0] wd);
    bus.if_req_i  = ir;
    bus.if_addr_i = 5'(ia);
    bus.d_req_i   = dr;
    bus.d_we_i    = dw;
    bus.d_addr_i  = 5'(da);
    bus.d_wdata_i = wd;
  endtask

  task automatic step(input logic ir, input int ia, input logic dr, input logic dw,
                      input int da, input logic [31:0] wd);
    @(posedge clk);
    #1 drive(ir, ia, dr, dw, da, wd);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      ram[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
    drive(1'b0, 0, 1'b0, 1'b0, 0, 32'h0);

    // IF-only back-to-back reads
    add(1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 2, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, -1);
    // D write then D read of the same word
    add(0, 0, 1, 1, 5, 32'hDEADBEEF, 0, 1, 0);
    add(0, 0, 1, 0, 5, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, -1);
    // Contention: D,D,D,IF repeating
    add(1, 3, 1, 0, 8,  0, 0, 1, 0);
    add(1, 3, 1, 0, 9,  0, 0, 1, 1);
    add(1, 3, 1, 0, 10, 0, 0, 1, 2);
    add(1, 3, 1, 0, 11, 0, 1, 0, 3);
    add(1, 4, 1, 0, 11, 0, 0, 1, 0);
    add(1, 4, 1, 0, 12, 0, 0, 1, 1);
    add(1, 4, 1, 0, 13, 0, 0, 1, 2);
    add(1, 4, 1, 0, 14, 0, 1, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, -1);

    repeat (2) @(posedge clk);
    #1;
    chk1("reset_if_gnt", bus.if_gnt_o, 1'b0);
    chk1("reset_if_rvalid", bus.if_rvalid_o, 1'b0);
    chk("reset_starve", 32'(dut.starve_cnt), 32'h0);
    rst = 1'b0;

    foreach (tbl[k]) begin
      step(tbl[k].if_req, 32'(tbl[k].if_addr), tbl[k].d_req, tbl[k].d_we,
           32'(tbl[k].d_addr), tbl[k].d_wdata);
      chk1($sformatf("vec%0d_if_gnt", k), bus.if_gnt_o, tbl[k].exp_if_gnt);
      chk1($sformatf("vec%0d_d_gnt", k), bus.d_gnt_o, tbl[k].exp_d_gnt);
      if (tbl[k].exp_cnt >= 0)
        chk($sformatf("vec%0d_starve", k), 32'(dut.starve_cnt), 32'(tbl[k].exp_cnt));
    end

    // Simultaneous reads: D first, IF next cycle, responses in order
    step(1, 2, 1, 0, 7, 0);
    chk1("sim_d_gnt", bus.d_gnt_o, 1'b1);
    chk1("sim_if_gnt0", bus.if_gnt_o, 1'b0);
    step(1, 2, 0, 0, 0, 0);
    chk1("sim_if_gnt1", bus.if_gnt_o, 1'b1);
    chk1("sim_d_rvalid", bus.d_rvalid_o, 1'b1);
    chk("sim_d_rdata", bus.d_rdata_o, init_word(7));
    chk1("sim_if_rvalid0", bus.if_rvalid_o, 1'b0);
    step(0, 0, 0, 0, 0, 0);
    chk1("sim_if_rvalid1", bus.if_rvalid_o, 1'b1);
    chk("sim_if_rdata", bus.if_rdata_o, init_word(2));
    chk1("sim_d_rvalid1", bus.d_rvalid_o, 1'b0);

    // Reset between grant and response
    step(1, 6, 0, 0, 0, 0);
    chk1("rr_gnt", bus.if_gnt_o, 1'b1);
    @(posedge clk);
    #1 drive(1, 6, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk1("rr_async_rvalid", bus.if_rvalid_o, 1'b0);
    chk1("rr_async_gnt", bus.if_gnt_o, 1'b0);
    chk1("rr_async_en", bus.mem_en_o, 1'b0);
    chk("rr_async_rdata", bus.if_rdata_o, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk1("rr_no_rvalid", bus.if_rvalid_o, 1'b0);
    step(1, 6, 0, 0, 0, 0);
    chk1("rr_post_gnt", bus.if_gnt_o, 1'b1);
    step(0, 0, 0, 0, 0, 0);
    chk1("rr_post_rvalid", bus.if_rvalid_o, 1'b1);
    chk("rr_post_rdata", bus.if_rdata_o, init_word(6));

    // IF withdraws while losing
    step(1, 9, 1, 0, 15, 0);
    chk("wd_cnt0", 32'(dut.starve_cnt), 32'h0);
    step(1, 9, 1, 0, 16, 0);
    chk("wd_cnt1", 32'(dut.starve_cnt), 32'h1);
    step(0, 0, 1, 0, 17, 0);
    chk("wd_cnt2", 32'(dut.starve_cnt), 32'h2);
    chk1("wd_if_gnt", bus.if_gnt_o, 1'b0);
    step(0, 0, 0, 0, 0, 0);
    chk("wd_cnt_clr", 32'(dut.starve_cnt), 32'h0);
    chk1("wd_if_rvalid", bus.if_rvalid_o, 1'b0);

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("drain_if", 32'(q_if.size()), 32'h0);
    chk("drain_d", 32'(q_d.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
